// File: rtl/pc_seq_if.sv
// Decode-to-fetch control bundle for pc_seq: sequencing controls in, PC and
// return-stack status out.
interface pc_seq_if #(
  parameter int unsigned D = 10
);
  logic         stall;
  logic         br_en;
  logic [D-1:0] br_offset;
  logic         jump_en;
  logic         call_en;
  logic         ret_en;
  logic [D-1:0] target;
  logic [D-1:0] prog_ctr;
  logic         ras_empty;
  logic         ras_full;
  logic         ras_err;

  modport master (
    output stall, br_en, br_offset, jump_en, call_en, ret_en, target,
    input  prog_ctr, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  stall, br_en, br_offset, jump_en, call_en, ret_en, target,
    output prog_ctr, ras_empty, ras_full, ras_err
  );
endinterface

// File: rtl/pc_seq.sv
// Fetch-stage program-counter sequencer: increment, relative branch, jump,
// stall and, when PC_SEQ_RAS_EN is defined, a circular return-address stack.
module pc_seq #(
  parameter int unsigned  D          = 10,
  parameter int unsigned  RAS_DEPTH  = 4,
  parameter logic [D-1:0] RESET_ADDR = '0
) (
  input  logic     clk,
  input  logic     reset_n,
  pc_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_BR,
    OP_JUMP,
    OP_CALL,
    OP_POP,
    OP_UNDER
  } op_e;

  logic [D-1:0] r_pc;
  logic [D-1:0] w_pc_inc;
  logic [D-1:0] w_pc_next;
  op_e          w_op;

  assign w_pc_inc = r_pc + D'(1);

`ifdef PC_SEQ_RAS_EN
  localparam int unsigned    AW       = $clog2(RAS_DEPTH);
  localparam int unsigned    CW       = AW + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(RAS_DEPTH);

  logic [D-1:0]  r_stack [RAS_DEPTH];
  logic [AW-1:0] r_sp;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          w_full;
  logic [D-1:0]  w_top;

  assign w_full = (r_cnt == FULL_CNT);
  // r_sp points at the next free slot, so the top lives one below it
  assign w_top  = r_stack[r_sp - AW'(1)];

  always_comb begin
    w_op = OP_INC;
    if (bus.stall)
      w_op = OP_HOLD;
    else if (bus.ret_en)
      w_op = (r_cnt != '0) ? OP_POP : OP_UNDER;
    else if (bus.call_en)
      w_op = OP_CALL;
    else if (bus.jump_en)
      w_op = OP_JUMP;
    else if (bus.br_en)
      w_op = OP_BR;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sp  <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      unique case (w_op)
        OP_CALL: begin
          // when full the write wraps onto the oldest entry
          r_sp <= r_sp + AW'(1);
          if (w_full)
            r_err <= 1'b1;
          else
            r_cnt <= r_cnt + CW'(1);
        end
        OP_POP: begin
          r_sp  <= r_sp - AW'(1);
          r_cnt <= r_cnt - CW'(1);
        end
        OP_UNDER: r_err <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && (w_op == OP_CALL))
      r_stack[r_sp] <= w_pc_inc;
  end

  assign bus.ras_empty = (r_cnt == '0);
  assign bus.ras_full  = w_full;
  assign bus.ras_err   = r_err;
`else
  logic [D-1:0] w_top;
  logic         w_unused;

  assign w_top    = '0;
  assign w_unused = &{1'b0, bus.ret_en, RAS_DEPTH[0]};

  // call degrades to a plain jump and return is ignored
  always_comb begin
    w_op = OP_INC;
    if (bus.stall)
      w_op = OP_HOLD;
    else if (bus.call_en || bus.jump_en)
      w_op = OP_JUMP;
    else if (bus.br_en)
      w_op = OP_BR;
  end

  assign bus.ras_empty = 1'b1;
  assign bus.ras_full  = 1'b0;
  assign bus.ras_err   = 1'b0;
`endif

  always_comb begin
    w_pc_next = w_pc_inc;
    unique case (w_op)
      OP_HOLD:           w_pc_next = r_pc;
      OP_BR:             w_pc_next = r_pc + bus.br_offset;
      OP_JUMP, OP_CALL:  w_pc_next = bus.target;
      OP_POP:            w_pc_next = w_top;
      OP_INC, OP_UNDER:  w_pc_next = w_pc_inc;
      default:           w_pc_next = w_pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      r_pc <= RESET_ADDR;
    else
      r_pc <= w_pc_next;
  end

  assign bus.prog_ctr = r_pc;

endmodule

// File: tb/tb_pc_seq.sv
// Directed self-checking bench for pc_seq (D=10, RAS_DEPTH=4); covers the
// PC_SEQ_RAS_EN build or the stackless build depending on the macro.
module tb_pc_seq;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  pc_seq_if #(.D(10)) bus ();

  pc_seq #(
    .D          (10),
    .RAS_DEPTH  (4),
    .RESET_ADDR (10'h000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall     = 1'b0;
    bus.br_en     = 1'b0;
    bus.br_offset = '0;
    bus.jump_en   = 1'b0;
    bus.call_en   = 1'b0;
    bus.ret_en    = 1'b0;
    bus.target    = '0;
  endtask

  task automatic do_jump(input logic [9:0] t);
    idle(); bus.jump_en = 1'b1; bus.target = t; tick(); idle();
  endtask

  task automatic do_call(input logic [9:0] t);
    idle(); bus.call_en = 1'b1; bus.target = t; tick(); idle();
  endtask

  task automatic do_ret();
    idle(); bus.ret_en = 1'b1; tick(); idle();
  endtask

  task automatic do_reset();
    idle(); reset_n = 1'b0; tick(); tick(); reset_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    idle();
    tick(); tick();
    check("rst_pc",    32'(bus.prog_ctr),  32'h000);
    check("rst_empty", 32'(bus.ras_empty), 32'h1);
    check("rst_full",  32'(bus.ras_full),  32'h0);
    check("rst_err",   32'(bus.ras_err),   32'h0);
    reset_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("inc", 32'(bus.prog_ctr), 32'(i));
    end

    do_jump(10'h3FE);
    check("jump", 32'(bus.prog_ctr), 32'h3FE);
    tick(); check("wrap0", 32'(bus.prog_ctr), 32'h3FF);
    tick(); check("wrap1", 32'(bus.prog_ctr), 32'h000);
    tick(); check("wrap2", 32'(bus.prog_ctr), 32'h001);

    do_jump(10'h005);
    bus.br_en = 1'b1; bus.br_offset = 10'h3FD; tick(); idle();
    check("br_neg", 32'(bus.prog_ctr), 32'h002);
    bus.br_en = 1'b1; bus.br_offset = 10'h010; tick(); idle();
    check("br_pos", 32'(bus.prog_ctr), 32'h012);
    do_jump(10'h3FC);
    bus.br_en = 1'b1; bus.br_offset = 10'h008; tick(); idle();
    check("br_wrap", 32'(bus.prog_ctr), 32'h004);

    bus.jump_en = 1'b1; bus.br_en = 1'b1; bus.br_offset = 10'h020; bus.target = 10'h200;
    tick(); idle();
    check("jump_over_br", 32'(bus.prog_ctr), 32'h200);

    for (int i = 0; i < 3; i++) begin
      bus.stall = 1'b1; bus.jump_en = 1'b1; bus.target = 10'h155;
      tick();
      check("stall_hold", 32'(bus.prog_ctr), 32'h200);
    end
    idle();

`ifdef PC_SEQ_RAS_EN
    do_jump(10'h010);
    do_call(10'h100);
    check("call1_pc",    32'(bus.prog_ctr),  32'h100);
    check("call1_empty", 32'(bus.ras_empty), 32'h0);
    do_call(10'h200);
    check("call2_pc", 32'(bus.prog_ctr), 32'h200);
    do_ret();
    check("ret1_pc", 32'(bus.prog_ctr), 32'h101);
    do_ret();
    check("ret2_pc",    32'(bus.prog_ctr),  32'h011);
    check("ret2_empty", 32'(bus.ras_empty), 32'h1);
    check("ret2_err",   32'(bus.ras_err),   32'h0);

    do_jump(10'h010);
    do_call(10'h020);
    do_call(10'h030);
    do_call(10'h040);
    check("c3_full", 32'(bus.ras_full), 32'h0);
    do_call(10'h050);
    check("c4_full", 32'(bus.ras_full), 32'h1);
    check("c4_err",  32'(bus.ras_err),  32'h0);
    do_call(10'h060);
    check("c5_full", 32'(bus.ras_full), 32'h1);
    check("c5_err",  32'(bus.ras_err),  32'h1);
    do_ret(); check("ovf_ret0", 32'(bus.prog_ctr), 32'h051);
    check("ovf_notfull", 32'(bus.ras_full), 32'h0);
    do_ret(); check("ovf_ret1", 32'(bus.prog_ctr), 32'h041);
    do_ret(); check("ovf_ret2", 32'(bus.prog_ctr), 32'h031);
    do_ret(); check("ovf_ret3", 32'(bus.prog_ctr), 32'h021);
    check("ovf_empty", 32'(bus.ras_empty), 32'h1);
    do_ret();
    check("under_pc",  32'(bus.prog_ctr), 32'h022);
    check("under_err", 32'(bus.ras_err),  32'h1);

    do_reset();
    check("rst2_err", 32'(bus.ras_err), 32'h0);
    for (int i = 0; i < 3; i++) begin
      bus.stall = 1'b1; bus.call_en = 1'b1; bus.target = 10'h300;
      tick();
      check("stall_call_pc",    32'(bus.prog_ctr),  32'h000);
      check("stall_call_empty", 32'(bus.ras_empty), 32'h1);
    end
    idle();
    do_call(10'h300);
    check("call3_pc", 32'(bus.prog_ctr), 32'h300);
    bus.ret_en = 1'b1; bus.call_en = 1'b1; bus.target = 10'h100;
    tick(); idle();
    check("retcall_pc",    32'(bus.prog_ctr),  32'h001);
    check("retcall_empty", 32'(bus.ras_empty), 32'h1);
    check("retcall_err",   32'(bus.ras_err),   32'h0);

    do_call(10'h2A0);
    bus.stall = 1'b1; bus.ret_en = 1'b1; reset_n = 1'b0;
    tick(); idle(); reset_n = 1'b1;
    check("midrst_pc",    32'(bus.prog_ctr),  32'h000);
    check("midrst_empty", 32'(bus.ras_empty), 32'h1);
`else
    do_call(10'h080);
    check("nras_call_pc",    32'(bus.prog_ctr),  32'h080);
    check("nras_call_empty", 32'(bus.ras_empty), 32'h1);
    do_ret();
    check("nras_ret_pc",  32'(bus.prog_ctr), 32'h081);
    check("nras_ret_err", 32'(bus.ras_err),  32'h0);
    check("nras_full",    32'(bus.ras_full), 32'h0);
    bus.ret_en = 1'b1; bus.jump_en = 1'b1; bus.target = 10'h123;
    tick(); idle();
    check("nras_retjump", 32'(bus.prog_ctr), 32'h123);
    bus.ret_en = 1'b1; bus.br_en = 1'b1; bus.br_offset = 10'h3FF;
    tick(); idle();
    check("nras_retbr", 32'(bus.prog_ctr), 32'h122);
    bus.stall = 1'b1; bus.call_en = 1'b1; bus.target = 10'h2A0; reset_n = 1'b0;
    tick(); idle(); reset_n = 1'b1;
    check("midrst_pc", 32'(bus.prog_ctr), 32'h000);
`endif

    tick();
    check("post_rst_inc", 32'(bus.prog_ctr), 32'h001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-counter sequencer for the processor fetch stage: the next generation of the single-target counter. Adds signed relative branches, a fetch stall, and a hardware return-address stack (RAS) for call/return, all with a single registered program counter. It drives the instruction-memory address directly and takes its control inputs from decode.

## Interface
Parameters:
- D, 10, program-counter and address width in bits.
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2).
- RESET_ADDR, 0, value loaded into prog_ctr on reset (D bits).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- stall  input  1  hold all state this cycle.
- br_en  input  1  relative branch: PC ← PC + br_offset.
- br_offset  input  D  two's-complement signed offset.
- jump_en  input  1  absolute jump: PC ← target.
- call_en  input  1  call: push PC+1, PC ← target.
- ret_en  input  1  return: PC ← popped address.
- target  input  D  absolute destination for jump/call.
- prog_ctr  output  D  current program counter (registered).
- ras_empty  output  1  stack holds 0 entries.
- ras_full  output  1  stack holds RAS_DEPTH entries.
- ras_err  output  1  sticky: overflow or underflow has occurred.

## Operation
- Per-edge priority: !reset_n > stall > ret_en > call_en > jump_en > br_en > increment.
- Reset: prog_ctr ← RESET_ADDR; stack count ← 0; ras_err ← 0; stack contents don't-care.
- stall=1: prog_ctr, stack pointer, count, ras_err all hold; other controls ignored.
- Increment: prog_ctr ← prog_ctr + 1.
- Branch: prog_ctr ← prog_ctr + br_offset (sign-extended, D-bit wrap).
- Jump: prog_ctr ← target.
- Call: push (prog_ctr + 1) mod 2^D; prog_ctr ← target; count +1.
- Call when full: push still performed, overwriting the oldest entry (circular buffer); count stays RAS_DEPTH; ras_err ← 1.
- Return with count>0: prog_ctr ← top entry; pop; count −1.
- Return when empty (underflow): no pop; prog_ctr ← prog_ctr + 1; ras_err ← 1.
- ras_err clears only on reset.
- Multiple enables asserted together: only the highest-priority one acts; the others have no effect (no push on a ret+call cycle).
- All PC arithmetic is modulo 2^D: 2^D−1 + 1 → 0; negative offsets wrap identically.

## Timing
- Single-cycle: controls sampled on edge N; prog_ctr reflects the result after edge N; no combinational path from inputs to any output.
- ras_empty/ras_full decoded from the registered count; they change the same edge as the push/pop.
- A return on the cycle immediately after a call returns the just-pushed address (no bypass hazard).
- Reset values: prog_ctr=RESET_ADDR, ras_empty=1, ras_full=0, ras_err=0.
- Reset asserted mid-sequence (stack non-empty, stall high) wins unconditionally on that edge.

## Configuration
- Macro PC_SEQ_RAS_EN.
- Defined: full RAS behaviour as above.
- Undefined: no stack storage; call_en acts as jump_en (no push); ret_en is ignored (the remaining priority chain applies); ras_empty tied 1, ras_full tied 0, ras_err tied 0.

## Test plan
- Reset then 5 idle cycles, D=10 -> prog_ctr 0,1,2,3,4,5; ras_empty=1, ras_err=0.
- PC=0x3FE, 3 increments -> 0x3FF, 0x000, 0x001; PC=0x005 with br_offset=0x3FD (−3) -> 0x002.
- PC=0x010 call target=0x100, call at 0x100 target=0x200, ret, ret -> 0x100, 0x200, 0x101, 0x011; ras_empty=1 at end, ras_err=0.
- RAS_DEPTH=4: 5 calls from PCs 0x10,0x20,0x30,0x40,0x50 -> ras_full after 4th, ras_err=1 after 5th; 4 rets yield 0x51,0x41,0x31,0x21; ret on empty -> PC+1, ras_err stays 1.
- stall=1 with call_en=1 for 3 cycles -> prog_ctr and count unchanged; ret_en+call_en same cycle with 1 entry -> pop only, ras_empty=1.
- Macro undefined: call_en target=0x080 -> prog_ctr 0x080, ras_empty=1; ret_en -> prog_ctr 0x081, ras_err=0.
